mdp_fifo_wr_arb: RTL
====================

Name: mdp_fifo_wr_arb

Overview:
- Write-side arbiter sharing one 64x256 single-clock message FIFO (scfifo64x256) between two MDP feed producers (channel A = ch0, channel B = ch1).
- Grants the FIFO write port one whole message at a time, round-robin.
- Admits a message only when the FIFO has room for all of it, so messages are never split or dropped inside the FIFO.
- Sits between the per-feed packet parsers and the FIFO; the read side is untouched.

Parameters:
- DATA_W, 64, word width of producer data and fifo_data.
- DEPTH, 256, FIFO depth in words.
- USEDW_W, 8, width of fifo_usedw.
- HEADROOM, 0, extra free words that must remain after an admitted message.

Ports:
- clk  in  1  rising-edge clock, shared with the FIFO's clock port.
- reset_n  in  1  asynchronous, active-low reset.
- ch0_req  in  1  ch0 has a complete message pending; held until its last word is accepted.
- ch0_len_m1  in  8  ch0 message length minus 1 (0..255 = 1..256 words); stable while ch0_req=1.
- ch0_data  in  DATA_W  ch0 word.
- ch0_valid  in  1  ch0_data is valid.
- ch0_last  in  1  ch0_data is the last word of the message.
- ch0_ready  out  1  ch0 word accepted when ch0_valid & ch0_ready.
- ch1_req, ch1_len_m1, ch1_data, ch1_valid, ch1_last, ch1_ready: same as ch0.
- fifo_data  out  DATA_W  FIFO write data.
- fifo_wrreq  out  1  FIFO write enable.
- fifo_usedw  in  USEDW_W  FIFO fill level; reads 0 when full.
- fifo_full  in  1  FIFO full flag.
- grant  out  2  one-hot current owner; 00 = none.
- len_err  out  1  one-cycle pulse on a message length mismatch.

Behaviour:
- Reset values: state=IDLE, grant=00, ch0_ready=ch1_ready=0, fifo_wrreq=0, len_err=0, word count=0. The round-robin pointer marks ch1 as last served, so ch0 wins the first tie.
- Free space: free = fifo_full ? 0 : DEPTH - fifo_usedw. Computed at USEDW_W+2 bits with no wrap.
- A channel fits when len_m1 + 1 + HEADROOM <= free.
- States:
  - IDLE: pick the priority requester, i.e. the requesting channel not last served, or the only requester.
    - If it fits: register grant, go to XFER on the next edge.
    - If it does not fit: stay in IDLE. The other channel is not allowed to bypass; this prevents starvation of long messages.
  - XFER:
    - Granted chN_ready = !fifo_full; the other channel's ready = 0.
    - fifo_wrreq = chN_valid & chN_ready, combinational. fifo_data = chN_data, combinational mux.
    - Each accepted word increments the word count.
  - End of message is the accepted word with last=1 or count==len_m1.
    - On that word: go to GAP, clear grant, set the round-robin pointer to N, clear the count.
    - If last=1 and count!=len_m1, or count==len_m1 and last=0: pulse len_err on the next cycle.
    - The message still ends at whichever condition occurs first.
  - GAP: one cycle with no grant, so fifo_usedw settles; then return to IDLE.
- Latency and throughput:
  - Grant is asserted 1 cycle after the IDLE cycle in which the requester fits.
  - First word can be written on that cycle.
  - 1 word/cycle within a message; 2 dead cycles between messages (GAP + IDLE).
- Requests: deassertion of chN_req during XFER is ignored; termination happens only via last/count.
- fifo_full during XFER (only possible with a misbehaving reader): ready drops, nothing is written, no data is lost, transfer resumes when full clears.
- Reset mid-XFER: outputs return to reset values immediately (asynchronous). The partially written message stays in the FIFO; downstream resynchronises on the MDP header.

Test Plan:
- Empty FIFO, ch0_req=1, len_m1=2, three valid words 0x1,0x2,0x3 with last on 0x3 -> grant=01 one cycle after the req cycle; fifo_wrreq high 3 consecutive cycles writing 1,2,3; grant=00 after the third word; len_err=0.
- ch0 and ch1 request in the same cycle, each len_m1=0, repeated 4 times -> grant order 01,10,01,10; 2 idle cycles between writes.
- fifo_usedw=250, ch1_req with len_m1=7 (8 words), ch0 last served -> no grant. Drive usedw to 248 -> grant=10 after one cycle. A ch0 request during the wait is not granted first.
- ch0 len_m1=3 with last on word 2 -> 2 words written, len_err pulse. Next: len_m1=1 with no last -> message ends after 2 words, len_err pulse.
- fifo_full asserted mid-XFER for 3 cycles -> ch0_ready=0 and fifo_wrreq=0 for those cycles; the remaining words are written afterwards in order.
- reset_n low during the second word of a 4-word message -> fifo_wrreq, grant and ready drop without waiting for clk. After release, state is IDLE and ch0 wins the first tie.

Source files
------------

// File: rtl/mdp_fifo_wr_arb.sv
// Purpose : Round-robin write-side arbiter sharing one message FIFO between two
//           MDP feed producers (ch0, ch1). Grants one whole message at a time,
//           and only when the FIFO has room for the entire message.
// Latency : grant 1 cycle after the IDLE cycle in which the requester fits;
//           1 word/cycle within a message; 2 dead cycles (GAP + IDLE) between messages.
// Backpr. : chN_ready = grant & !fifo_full; fifo_wrreq = valid & ready (combinational).
// Ports   : chN_* producer request/length/data/valid/last/ready, fifo_* write port
//           and fill status, grant (one-hot owner), len_err (length mismatch pulse).
module mdp_fifo_wr_arb #(
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 256,
  parameter int USEDW_W  = 8,
  parameter int HEADROOM = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ch0_req,
  input  logic [7:0]        ch0_len_m1,
  input  logic [DATA_W-1:0] ch0_data,
  input  logic              ch0_valid,
  input  logic              ch0_last,
  output logic              ch0_ready,
  input  logic              ch1_req,
  input  logic [7:0]        ch1_len_m1,
  input  logic [DATA_W-1:0] ch1_data,
  input  logic              ch1_valid,
  input  logic              ch1_last,
  output logic              ch1_ready,
  output logic [DATA_W-1:0] fifo_data,
  output logic              fifo_wrreq,
  input  logic [USEDW_W-1:0] fifo_usedw,
  input  logic              fifo_full,
  output logic [1:0]        grant,
  output logic              len_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Two extra bits so DEPTH itself and len+1+HEADROOM never wrap.
  localparam int FW = USEDW_W + 2;

  logic [1:0] state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       rr_q, rr_d;        // last served channel: 1 = ch1
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] len_q, len_d;      // len_m1 of the owner, captured at grant
  logic       len_err_q, len_err_d;

  logic [FW-1:0] free_words;
  logic [FW-1:0] need0, need1;
  logic          pick1, any_req, pick_fits;
  logic          sel1, sel_valid, sel_last, acc, cnt_hit, eom;

  assign free_words = fifo_full ? '0 : (FW'(DEPTH) - FW'(fifo_usedw));
  assign need0      = FW'(ch0_len_m1) + FW'(1) + FW'(HEADROOM);
  assign need1      = FW'(ch1_len_m1) + FW'(1) + FW'(HEADROOM);

  // Priority requester: the one not served last, or the sole requester.
  // If it does not fit, nobody is granted, so long messages cannot starve.
  assign any_req   = ch0_req | ch1_req;
  assign pick1     = ch1_req & (~ch0_req | ~rr_q);
  assign pick_fits = pick1 ? (need1 <= free_words) : (need0 <= free_words);

  // grant_q is only non-zero in XFER, so it gates ready and wrreq directly.
  assign sel1      = grant_q[1];
  assign ch0_ready = grant_q[0] & ~fifo_full;
  assign ch1_ready = grant_q[1] & ~fifo_full;
  assign sel_valid = sel1 ? ch1_valid : ch0_valid;
  assign sel_last  = sel1 ? ch1_last  : ch0_last;
  assign acc       = sel_valid & (ch0_ready | ch1_ready);
  assign cnt_hit   = (cnt_q == len_q);
  assign eom       = acc & (sel_last | cnt_hit);

  assign fifo_wrreq = acc;
  assign fifo_data  = sel1 ? ch1_data : ch0_data;
  assign grant      = grant_q;
  assign len_err    = len_err_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    len_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req && pick_fits) begin
          grant_d = pick1 ? 2'b10 : 2'b01;
          len_d   = pick1 ? ch1_len_m1 : ch0_len_m1;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (eom) begin
          // Message ends on whichever of last / count comes first; a
          // disagreement between the two is flagged.
          state_d   = ST_GAP;
          grant_d   = 2'b00;
          rr_d      = sel1;
          cnt_d     = 8'd0;
          len_err_d = sel_last ^ cnt_hit;
        end else if (acc) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_GAP: begin
        // Lets fifo_usedw reflect the last message before the next fit check.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= 2'b00;
      rr_q      <= 1'b1;
      cnt_q     <= 8'd0;
      len_q     <= 8'd0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      len_err_q <= len_err_d;
    end
  end

endmodule
